// File: rtl/data_mem_waitstate.sv
// Word-addressed data RAM slave with a programmable wait-state handshake.
// Byte-lane writes and a sticky access-error flag.
module data_mem_waitstate #(
  parameter string       DATA_INIT_FILE = "",
  parameter int          BLOCK_SIZE     = 8192,
  parameter logic [31:0] BASE_ADDR      = 32'h00001000,
  parameter int          WAIT_CYCLES    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        access_error
);

  localparam int          AW       = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [31:0] DEPTH    = 32'(BLOCK_SIZE);
  localparam logic [4:0]  WAIT_LIM = 5'(WAIT_CYCLES);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // Zero-initialised so in-range reads of unwritten words never return X.
  logic [3:0][7:0] ram [BLOCK_SIZE] = '{default: '0};

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] rd_hold_reg;
  logic        err_reg;

  logic        req;
  logic        complete;
  logic [4:0]  cnt_inc;
  logic [31:0] offset;
  logic        in_range;
  logic [AW-1:0] idx;
  logic [31:0] rd_now;
  logic        do_write;
  logic        error_now;
  logic [3:0][7:0] wr_word;

  assign req      = read | write;
  assign cnt_inc  = {1'b0, cnt_reg} + 5'd1;
  assign offset   = address - BASE_ADDR;
  assign in_range = (address >= BASE_ADDR) && ({2'b00, offset[31:2]} < DEPTH);
  assign idx      = offset[AW+1:2];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    complete   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req) begin
          addr_next = address;
          cnt_next  = '0;
          if (WAIT_CYCLES == 0) complete = 1'b1;
          else                  state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else if (address != addr_reg) begin
          // Master moved the address mid-access: start the count over.
          addr_next = address;
          cnt_next  = '0;
        end else if (cnt_inc == WAIT_LIM) begin
          complete   = 1'b1;
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc[3:0];
        end
      end
      default: state_next = S_IDLE;
    endcase
    // An access never completes while reset is held, so no write can land.
    if (reset) complete = 1'b0;
  end

  assign error_now   = (read & write) | ~in_range;
  assign rd_now      = (write || !in_range) ? 32'h0 : ram[idx];
  assign readdata    = (complete && read) ? rd_now : rd_hold_reg;
  assign waitrequest = req & ~complete & ~reset;
  assign access_error = err_reg;
  assign do_write    = complete & write & ~read & in_range;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wr_word[gi] = byteenable[gi] ? writedata[8*gi +: 8] : ram[idx][gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      rd_hold_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      if (complete) begin
        if (read)      rd_hold_reg <= rd_now;
        if (error_now) err_reg     <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) ram[idx] <= wr_word;
  end

endmodule

// File: tb/tb_data_mem_waitstate.sv
// Directed bench for data_mem_waitstate: one instance with two wait states,
// one with none, sharing address/data buses and selected by dut_sel.
module tb_data_mem_waitstate;

  localparam logic [31:0] BASE = 32'h00001000;
  localparam int          BS   = 16;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [31:0] address;
  logic        req_rd, req_wr;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        dut_sel;

  logic        read_a, write_a, read_b, write_b;
  logic [31:0] rdata_a, rdata_b;
  logic        wait_a, wait_b, err_a, err_b;
  logic [31:0] rd_obs;
  logic        wait_obs, err_obs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign read_a   = req_rd & ~dut_sel;
  assign write_a  = req_wr & ~dut_sel;
  assign read_b   = req_rd & dut_sel;
  assign write_b  = req_wr & dut_sel;
  assign rd_obs   = dut_sel ? rdata_b : rdata_a;
  assign wait_obs = dut_sel ? wait_b : wait_a;
  assign err_obs  = dut_sel ? err_b : err_a;

  data_mem_waitstate #(.DATA_INIT_FILE(""), .BLOCK_SIZE(BS), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .reset(rst_a), .address(address), .read(read_a), .write(write_a),
    .byteenable(byteenable), .writedata(writedata), .readdata(rdata_a),
    .waitrequest(wait_a), .access_error(err_a)
  );

  data_mem_waitstate #(.DATA_INIT_FILE(""), .BLOCK_SIZE(BS), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .reset(rst_b), .address(address), .read(read_b), .write(write_b),
    .byteenable(byteenable), .writedata(writedata), .readdata(rdata_b),
    .waitrequest(wait_b), .access_error(err_b)
  );

  // Holds the request until waitrequest drops, counting cycles to completion.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        output int cycles, output logic [31:0] rdata, output logic err_done);
    bit done = 0;
    req_rd = rd; req_wr = wr; address = addr; writedata = wd; byteenable = be;
    cycles = 0; rdata = '0; err_done = 1'b0;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (wait_obs === 1'b0) begin
        done = 1; rdata = rd_obs; err_done = err_obs;
      end
      @(posedge clk); #1;
    end
    req_rd = 0; req_wr = 0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL access_timeout: waitrequest still 1 after %0d cycles, required 0", cycles);
    end
    $display("dut=%0d rd=%0b wr=%0b addr=%h wd=%h be=%b cycles=%0d rdata=%h err=%0b",
             dut_sel, rd, wr, addr, wd, be, cycles, rdata, err_done);
  endtask

  task automatic test_reset;
    #1;
    checks++; if (wait_a !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b want 0", wait_a); end
    checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 00000000", rdata_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_a); end
    checks++; if (rdata_b !== 32'h0) begin errors++; $display("FAIL reset_rdata_b: got %h want 00000000", rdata_b); end
  endtask

  task automatic test_read(input int exp_cyc);
    int c; logic [31:0] d; logic e;
    access(0, 1, BASE, 32'hDEADBEEF, 4'hF, c, d, e);
    checks++; if (c !== exp_cyc) begin errors++; $display("FAIL init_write_cycles: got %0d want %0d", c, exp_cyc); end
    access(1, 0, BASE, 32'h0, 4'h0, c, d, e);
    checks++; if (c !== exp_cyc) begin errors++; $display("FAIL read_cycles: got %0d want %0d", c, exp_cyc); end
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data: got %h want deadbeef", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL read_err: got %b want 0", e); end
    @(negedge clk);
    checks++; if (rd_obs !== 32'hDEADBEEF) begin errors++; $display("FAIL read_hold: got %h want deadbeef", rd_obs); end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_write(input int exp_cyc);
    int c; logic [31:0] d; logic e;
    access(0, 1, BASE + 4, 32'hAABBCCDD, 4'hF, c, d, e);
    checks++; if (c !== exp_cyc) begin errors++; $display("FAIL full_write_cycles: got %0d want %0d", c, exp_cyc); end
    access(0, 1, BASE + 4, 32'h11223344, 4'b0101, c, d, e);
    checks++; if (c !== exp_cyc) begin errors++; $display("FAIL byte_write_cycles: got %0d want %0d", c, exp_cyc); end
    access(1, 0, BASE + 4, 32'h0, 4'h0, c, d, e);
    checks++; if (c !== exp_cyc) begin errors++; $display("FAIL byte_read_cycles: got %0d want %0d", c, exp_cyc); end
    checks++; if (d !== 32'hAA22CC44) begin errors++; $display("FAIL byte_merge: got %h want aa22cc44", d); end
  endtask

  task automatic test_abort;
    int c; logic [31:0] d; logic e;
    address = BASE + 4; writedata = 32'hCAFEF00D; byteenable = 4'hF; req_wr = 1;
    @(negedge clk);
    checks++; if (wait_a !== 1'b1) begin errors++; $display("FAIL abort_wait_pre: got %b want 1", wait_a); end
    @(posedge clk); #1;
    req_wr = 0;
    @(negedge clk);
    checks++; if (wait_a !== 1'b0) begin errors++; $display("FAIL abort_wait_idle: got %b want 0", wait_a); end
    @(posedge clk); #1;
    $display("dut=0 aborted write addr=%h wd=cafef00d", BASE + 4);
    access(1, 0, BASE + 4, 32'h0, 4'h0, c, d, e);
    checks++; if (d !== 32'hAA22CC44) begin errors++; $display("FAIL abort_data: got %h want aa22cc44", d); end
    checks++; if (c !== 3) begin errors++; $display("FAIL abort_next_cycles: got %0d want 3", c); end
  endtask

  task automatic test_out_of_range;
    int c; logic [31:0] d; logic e;
    access(1, 0, BASE - 4, 32'h0, 4'h0, c, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL oor_low_data: got %h want 00000000", d); end
    checks++; if (c !== 3) begin errors++; $display("FAIL oor_low_cycles: got %0d want 3", c); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL oor_err_before_edge: got %b want 0", e); end
    checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL oor_err_after_edge: got %b want 1", err_a); end
    access(1, 0, BASE + 4 * BS, 32'h0, 4'h0, c, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL oor_high_data: got %h want 00000000", d); end
    access(1, 0, BASE, 32'h0, 4'h0, c, d, e);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL oor_recover_data: got %h want deadbeef", d); end
    checks++; if (c !== 3) begin errors++; $display("FAIL oor_recover_cycles: got %0d want 3", c); end
    checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err_a); end
  endtask

  task automatic test_async_reset;
    int c; logic [31:0] d; logic e;
    access(0, 1, BASE + 8, 32'h12345678, 4'hF, c, d, e);
    address = BASE + 8; writedata = 32'h55555555; byteenable = 4'hF; req_wr = 1;
    @(negedge clk);
    @(posedge clk); #3;
    rst_a = 1;
    #1;
    checks++; if (wait_a !== 1'b0) begin errors++; $display("FAIL arst_wait: got %b want 0", wait_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL arst_err: got %b want 0", err_a); end
    checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL arst_rdata: got %h want 00000000", rdata_a); end
    req_wr = 0;
    @(posedge clk); #3;
    rst_a = 0;
    @(posedge clk); #1;
    $display("dut=0 reset during write addr=%h wd=55555555", BASE + 8);
    access(1, 0, BASE + 8, 32'h0, 4'h0, c, d, e);
    checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL arst_word_kept: got %h want 12345678", d); end
    checks++; if (c !== 3) begin errors++; $display("FAIL arst_next_cycles: got %0d want 3", c); end
  endtask

  initial begin
    rst_a = 1; rst_b = 1; dut_sel = 0;
    req_rd = 0; req_wr = 0; address = '0; writedata = '0; byteenable = '0;
    #12;
    test_reset;
    @(posedge clk); #1;
    rst_a = 0; rst_b = 0;
    @(posedge clk); #1;
    test_read(3);
    test_byte_write(3);
    test_abort;
    test_out_of_range;
    test_async_reset;
    dut_sel = 1;
    test_read(1);
    test_byte_write(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
